cdc_handshake_sender: RTL and testbench

- Source-side half of a toggle req/ack handshake that carries a multi-bit word across a clock-domain crossing.
- Accepts a word from local logic with a valid/ready handshake and holds it stable on data_out.
- Toggles req_toggle, then waits until the destination's ack_toggle, after an internal 2-flop synchronizer, equals req_toggle.
- Pairs with the bit-wise double-flop synchronizer that the destination domain runs on req_toggle.

---
 rtl/cdc_handshake_sender.sv | 115 +++++++++++
 tb/tb_cdc_handshake_sender.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_sender.sv
// Source half of a toggle req/ack CDC handshake: holds one word on data_out per req flip.
// Optional ack-timeout pulse enabled by defining CDC_SEND_TIMEOUT_EN.
module cdc_handshake_sender #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_toggle,
  input  logic             ack_toggle,
  output logic             busy,
  output logic             send_done,
  output logic             timeout
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic             sync1_q, sync2_q;
  logic             done_q, done_d;
  logic             ack_match, accept;

  // ack_toggle is only ever seen through the two-flop synchronizer
  assign ack_match = (sync2_q == req_q);
  assign in_ready  = (state_q == S_IDLE) & ack_match & ~rst;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        data_d  = in_data;
        req_d   = ~req_q;
        state_d = S_WAIT;
      end
      default: if (ack_match) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      sync1_q <= ack_toggle;
      sync2_q <= sync1_q;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign req_toggle = req_q;
  assign busy       = (state_q == S_WAIT);
  assign send_done  = done_q;

`ifdef CDC_SEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Saturating one past the fire point guarantees a single pulse per transfer
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && cnt_q != CNT_SAT) begin
      cnt_d     = cnt_q + CW'(1);
      timeout_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Randomized + directed bench for cdc_handshake_sender against a transaction-level reference model.
module tb_cdc_handshake_sender;
  localparam int W = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         ack_toggle = 1'b0;
  logic         in_ready, req_toggle, busy, send_done, timeout;
  logic [W-1:0] data_out;

  cdc_handshake_sender #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_out(data_out), .req_toggle(req_toggle), .ack_toggle(ack_toggle), .busy(busy),
    .send_done(send_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a word is "in flight" from accept until the destination ack
  // (seen two source edges late) equals the request level.
  bit           m_busy, m_req, m_done, m_to;
  logic [W-1:0] m_data;
  bit           m_ack_hist[$];
  int           m_waited, m_n_done, dut_n_done, n_acc;

  bit resp_on = 0;
  int resp_dly = 0, resp_cnt = 0;

  task automatic m_reset();
    m_busy = 0; m_req = 0; m_done = 0; m_to = 0; m_data = '0; m_waited = 0;
    m_ack_hist = {1'b0, 1'b0};
  endtask

  function automatic bit m_ready();
    return !m_busy && (m_ack_hist[0] == m_req);
  endfunction

  task automatic m_edge(input bit v, input logic [W-1:0] d, input bit ack);
    bit acc, was_busy;
    acc      = v && m_ready();
    was_busy = m_busy;
    m_done   = was_busy && (m_ack_hist[0] == m_req);
    m_to     = 0;
    if (was_busy) begin
      m_waited++;
`ifdef CDC_SEND_TIMEOUT_EN
      m_to = (m_waited == T);
`endif
    end
    if (m_done) begin m_busy = 0; m_n_done++; end
    if (acc) begin
      m_busy = 1; m_req = !m_req; m_data = d; m_waited = 0; n_acc++;
    end
    m_ack_hist.push_back(ack);
    void'(m_ack_hist.pop_front());
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".rdy"},  in_ready,   m_ready());
    chk({tag, ".data"}, data_out,   m_data);
    chk({tag, ".req"},  req_toggle, m_req);
    chk({tag, ".busy"}, busy,       m_busy);
    chk({tag, ".done"}, send_done,  m_done);
    chk({tag, ".to"},   timeout,    m_to);
  endtask

  // One clock: optional auto-responder drives ack, inputs applied, edge, model, compare.
  task automatic step(input string tag, input bit v, input logic [W-1:0] d);
    if (resp_on && req_toggle !== ack_toggle) begin
      if (resp_cnt >= resp_dly) begin
        ack_toggle = req_toggle;
        resp_cnt   = 0;
        resp_dly   = $urandom_range(0, 20);
      end else resp_cnt++;
    end
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    m_edge(v, d, ack_toggle);
    #1;
    check_outs(tag);
    if (send_done === 1'b1) dut_n_done++;
  endtask

  task automatic async_reset_check(input string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, ".rdy"},  in_ready,   0);
    chk({tag, ".data"}, data_out,   0);
    chk({tag, ".req"},  req_toggle, 0);
    chk({tag, ".busy"}, busy,       0);
    chk({tag, ".done"}, send_done,  0);
    chk({tag, ".to"},   timeout,    0);
  endtask

  initial begin
    logic [W-1:0] words [3];
    int idx, d0, a0, t0;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    m_reset();
    #1 check_outs("reset");

    // single word, in_valid keeps pushing new data while the transfer waits
    repeat (5) step("idle", 1'b0, W'($urandom));
    d0 = dut_n_done;
    step("a5.acc", 1'b1, 8'hA5);
    chk("a5.data_now", data_out, 8'hA5);
    repeat (3) step("a5.hold", 1'b1, W'($urandom));
    chk("a5.held", data_out, 8'hA5);
    ack_toggle = 1'b1;
    repeat (6) step("a5.ack", 1'b0, W'($urandom));
    chk("a5.done_cnt", dut_n_done - d0, 1);
    chk("a5.rdy_after", in_ready, 1);

    // back-to-back with immediate acks
    resp_on = 1; resp_dly = 0; resp_cnt = 0;
    d0 = dut_n_done; a0 = n_acc; idx = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      step("b2b", 1'b1, words[idx]);
      if (n_acc != a0 + idx) idx++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && busy; c++) step("b2b.drain", 1'b0, 8'h00);
    chk("b2b.words", idx, 3);
    chk("b2b.done_cnt", dut_n_done - d0, 3);

    // reset mid-transfer, destination still reports a stale ack level of 1
    resp_on = 0;
    step("rmid.acc", 1'b1, 8'h3C);
    step("rmid.w", 1'b0, 8'h00);
    async_reset_check("rmid");
    ack_toggle = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m_reset();
    repeat (3) step("rmid.rel", 1'b0, 8'h00);
    repeat (5) step("rmid.stale", 1'b1, W'($urandom));
    chk("rmid.stale_rdy", in_ready, 0);
    ack_toggle = 1'b0;
    repeat (4) step("rmid.clear", 1'b0, 8'h00);
    chk("rmid.rdy_back", in_ready, 1);

    // no ack for a long time, then a late ack
    d0 = dut_n_done; t0 = 0;
    step("to.acc", 1'b1, 8'h77);
    for (int c = 0; c < 24; c++) begin
      step("to.wait", 1'b0, 8'h00);
      if (timeout === 1'b1) t0++;
    end
`ifdef CDC_SEND_TIMEOUT_EN
    chk("to.pulses", t0, 1);
`else
    chk("to.pulses", t0, 0);
`endif
    chk("to.busy", busy, 1);
    ack_toggle = 1'b1;
    repeat (5) step("to.late", 1'b0, 8'h00);
    chk("to.done_cnt", dut_n_done - d0, 1);

    // randomized traffic with a random-latency responder
    resp_on = 1; resp_cnt = 0; resp_dly = 0;
    for (int c = 0; c < 1500; c++) step("rand", ($urandom_range(0, 1) == 1), W'($urandom));
    chk("sb.done_total", dut_n_done, m_n_done);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
